// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution engine: FSM state encoding,
// kernel size, default image geometry and the accumulator-width helper.
// Ports: none (package only).
package conv_pkg;

    localparam int NUM_KERNEL = 9;
    localparam int IMG_W_DEF  = 10;
    localparam int IMG_H_DEF  = 9;
    localparam int PIX_W_DEF  = 8;

    // A 9-term sum of (unsigned PIX_W) x (signed PIX_W) products needs
    // 2*PIX_W bits for one product plus 4 bits of growth plus sign.
    function automatic int acc_w(input int pix_w);
        return 2 * pix_w + 5;
    endfunction

    typedef enum logic [1:0] {
        LOAD_KERNEL = 2'd0,
        LOAD_IMAGE  = 2'd1,
        DRAIN       = 2'd2,
        DONE        = 2'd3
    } conv_state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: DEPTH-entry WIDTH-bit shift register, advanced by en_i.
// Latency: dout_o is the value written DEPTH enabled shifts earlier.
// Ports: clk_i, rst_ni (async active-low), en_i shift, clr_i sync clear, din_i, dout_o.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int WIDTH = PIX_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
        end
    end

    // Oldest entry: same column, previous row, seen before the shift.
    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 convolution core: loads a 9-byte signed kernel, then streams IMG_H*IMG_W
// unsigned pixels through two line buffers and a 3x3 window, emitting one result
// per fully-inside window, 2 edges after the window's bottom-right pixel is sampled.
// Ports: Phi2 clock, Reset_n_s1 async active-low reset, Input_Ready_s1 byte request,
// Pixel_s1 byte (valid the cycle after its request), Start_s1 restart pulse (DONE only),
// Result_s1/Result_Valid_s1 result and pulse, Done_s1 idle indicator.
// Optional build macro CONV3X3_SAT_EN: clamp results to [0, 2^PIX_W-1].
module conv3x3_engine
    import conv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF,
    parameter int ACC_W = acc_w(PIX_W)
) (
    input  logic             Phi2,
    input  logic             Reset_n_s1,
    output logic             Input_Ready_s1,
    input  logic [PIX_W-1:0] Pixel_s1,
    input  logic             Start_s1,
    output logic [ACC_W-1:0] Result_s1,
    output logic             Result_Valid_s1,
    output logic             Done_s1
);

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int REQ_W  = $clog2(NPIX + 1);
    localparam int ROW_W  = $clog2(IMG_H + 1);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int KIDX_W = $clog2(NUM_KERNEL);

    localparam logic [REQ_W-1:0]  LAST_KREQ = REQ_W'(NUM_KERNEL - 1);
    localparam logic [REQ_W-1:0]  LAST_PREQ = REQ_W'(NPIX - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [KIDX_W-1:0] LAST_KIDX = KIDX_W'(NUM_KERNEL - 1);
    localparam logic [ROW_W-1:0]  ROW_TWO   = ROW_W'(2);
    localparam logic [COL_W-1:0]  COL_TWO   = COL_W'(2);

    // ---------------- control state ----------------
    conv_state_e       state_q;
    logic              rdy_q;
    logic [REQ_W-1:0]  req_cnt_q;
    logic              pend_kern_q;   // a kernel byte is due on Pixel_s1 this cycle
    logic              pend_pix_q;    // an image pixel is due on Pixel_s1 this cycle
    logic              done_q;

    // ---------------- datapath state ----------------
    logic [KIDX_W-1:0] kidx_q;
    logic [PIX_W-1:0]  kern_q [NUM_KERNEL];
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [PIX_W-1:0]  pix_q;
    logic              smp_vld_q;     // pix_q holds a freshly sampled pixel
    logic              smp_ok_q;      // ... and that pixel closes a full window
    logic [PIX_W-1:0]  win_q [3][3];  // [row][col], row 0 = oldest image row
    logic              win_ok_q;
    logic [ACC_W-1:0]  res_q;
    logic              res_vld_q;

    logic                    start_clr;
    logic [PIX_W-1:0]        lb1_dout;
    logic [PIX_W-1:0]        lb2_dout;
    logic signed [ACC_W-1:0] sum_d;
    logic [ACC_W-1:0]        res_d;

    // Restart from DONE: clears geometry and line buffers, kernel is kept.
    assign start_clr = (state_q == DONE) && Start_s1;

    // ---------------- FSM and request generation ----------------
    always_ff @(posedge Phi2 or negedge Reset_n_s1) begin
        if (!Reset_n_s1) begin
            state_q     <= LOAD_KERNEL;
            rdy_q       <= 1'b0;
            req_cnt_q   <= '0;
            pend_kern_q <= 1'b0;
            pend_pix_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pend_kern_q <= 1'b0;
            pend_pix_q  <= 1'b0;
            case (state_q)
                LOAD_KERNEL: begin
                    // The request line stays high across the hand-over to
                    // LOAD_IMAGE so the byte stream has no bubble.
                    rdy_q <= 1'b1;
                    if (rdy_q) begin
                        pend_kern_q <= 1'b1;
                        if (req_cnt_q == LAST_KREQ) begin
                            req_cnt_q <= '0;
                            state_q   <= LOAD_IMAGE;
                        end else begin
                            req_cnt_q <= req_cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_IMAGE: begin
                    if (rdy_q) begin
                        pend_pix_q <= 1'b1;
                        if (req_cnt_q == LAST_PREQ) begin
                            rdy_q     <= 1'b0;
                            req_cnt_q <= '0;
                            state_q   <= DRAIN;
                        end else begin
                            req_cnt_q <= req_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Empty once the last pixel has passed sample, window and result stages.
                    if (!pend_pix_q && !smp_vld_q && !win_ok_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (Start_s1) begin
                        state_q   <= LOAD_IMAGE;
                        rdy_q     <= 1'b1;
                        req_cnt_q <= '0;
                        done_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= LOAD_KERNEL;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- line buffers: rows r-1 and r-2 ----------------
    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_row1 (
        .clk_i  (Phi2),
        .rst_ni (Reset_n_s1),
        .en_i   (smp_vld_q),
        .clr_i  (start_clr),
        .din_i  (pix_q),
        .dout_o (lb1_dout)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_row2 (
        .clk_i  (Phi2),
        .rst_ni (Reset_n_s1),
        .en_i   (smp_vld_q),
        .clr_i  (start_clr),
        .din_i  (lb1_dout),
        .dout_o (lb2_dout)
    );

    // ---------------- 9-term MAC ----------------
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum_d = sum_d
                      + ($signed({{(ACC_W-PIX_W){kern_q[3*i+j][PIX_W-1]}}, kern_q[3*i+j]})
                       * $signed({{(ACC_W-PIX_W){1'b0}}, win_q[i][j]}));
            end
        end
    end

`ifdef CONV3X3_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << PIX_W) - 1);

    always_comb begin
        if (sum_d[ACC_W-1]) begin
            res_d = '0;
        end else if (sum_d > SAT_MAX) begin
            res_d = SAT_MAX;
        end else begin
            res_d = $unsigned(sum_d);
        end
    end
`else
    always_comb begin
        res_d = $unsigned(sum_d);
    end
`endif

    // ---------------- sample, window and result pipeline ----------------
    always_ff @(posedge Phi2 or negedge Reset_n_s1) begin
        if (!Reset_n_s1) begin
            kidx_q    <= '0;
            for (int k = 0; k < NUM_KERNEL; k++) kern_q[k] <= '0;
            row_q     <= '0;
            col_q     <= '0;
            pix_q     <= '0;
            smp_vld_q <= 1'b0;
            smp_ok_q  <= 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
            win_ok_q  <= 1'b0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            if (pend_kern_q) begin
                kern_q[kidx_q] <= Pixel_s1;
                kidx_q         <= (kidx_q == LAST_KIDX) ? '0 : kidx_q + 1'b1;
            end

            smp_vld_q <= pend_pix_q;
            if (pend_pix_q) begin
                pix_q    <= Pixel_s1;
                // Only pixels at c>=2, r>=2 close a window that does not wrap a row.
                smp_ok_q <= (row_q >= ROW_TWO) && (col_q >= COL_TWO);
                if (col_q == LAST_COL) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            if (start_clr) begin
                row_q <= '0;
                col_q <= '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) win_q[i][j] <= '0;
            end else if (smp_vld_q) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb2_dout;
                win_q[1][2] <= lb1_dout;
                win_q[2][2] <= pix_q;
            end

            win_ok_q  <= smp_vld_q && smp_ok_q;
            res_vld_q <= win_ok_q;
            if (win_ok_q) res_q <= res_d;
        end
    end

    assign Input_Ready_s1  = rdy_q;
    assign Result_s1       = res_q;
    assign Result_Valid_s1 = res_vld_q;
    assign Done_s1         = done_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine: acts as the byte stimulus (answers each
// request one cycle later), predicts results from the convolution definition and
// compares every result pulse. Honours CONV3X3_SAT_EN in its reference model.
module tb_conv3x3_engine;

    localparam int W     = 10;
    localparam int H     = 9;
    localparam int NUM_K = 9;
    localparam int NRES  = (H - 2) * (W - 2);

    logic        Phi2;
    logic        Reset_n_s1;
    logic        Input_Ready_s1;
    logic [7:0]  Pixel_s1;
    logic        Start_s1;
    logic [20:0] Result_s1;
    logic        Result_Valid_s1;
    logic        Done_s1;

    conv3x3_engine dut (
        .Phi2            (Phi2),
        .Reset_n_s1      (Reset_n_s1),
        .Input_Ready_s1  (Input_Ready_s1),
        .Pixel_s1        (Pixel_s1),
        .Start_s1        (Start_s1),
        .Result_s1       (Result_s1),
        .Result_Valid_s1 (Result_Valid_s1),
        .Done_s1         (Done_s1)
    );

    initial begin
        Phi2 = 1'b0;
        forever #5 Phi2 = ~Phi2;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]        byte_q[$];
    int                exp_q[$];
    logic signed [7:0] kern[NUM_K];
    logic [7:0]        img[W*H];

    int pop_total = 0;
    int smp_edge[4096];
    int req_cnt = 0;
    int underflow = 0;
    int res_cnt = 0;
    int first_res = 0;
    int last_res = 0;
    int first_cyc = 0;

    always @(posedge Phi2) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: every window fully inside the image, row-major order.
    task automatic push_expected();
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                int s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += int'(kern[3*i+j]) * int'(img[(r-2+i)*W + (c-2+j)]);
`ifdef CONV3X3_SAT_EN
                if (s < 0) s = 0;
                else if (s > 255) s = 255;
`endif
                exp_q.push_back(s);
            end
        end
    endtask

    // Stimulus side of the handshake: a request seen before edge N is answered
    // with a byte driven after edge N, so the DUT samples it at edge N+1.
    initial begin : driver
        bit rdy;
        Pixel_s1 = '0;
        forever begin
            @(negedge Phi2);
            rdy = Input_Ready_s1 && Reset_n_s1;
            @(posedge Phi2);
            #1;
            if (rdy && Reset_n_s1) begin
                req_cnt++;
                if (byte_q.size() > 0) begin
                    Pixel_s1 = byte_q.pop_front();
                    if (pop_total < 4096) smp_edge[pop_total] = cyc + 1;
                    pop_total++;
                end else begin
                    underflow++;
                    Pixel_s1 = 8'($urandom);
                end
            end else begin
                Pixel_s1 = 8'($urandom);
            end
        end
    end

    // Result compare against the model queue.
    always @(negedge Phi2) begin
        if (Reset_n_s1 && Result_Valid_s1) begin
            int got;
            got = int'($signed(Result_s1));
            if (res_cnt == 0) begin
                first_res = got;
                first_cyc = cyc;
            end
            last_res = got;
            res_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL result_unexpected: got %0d, expected no result", got);
            end else begin
                chk("result", got, exp_q.pop_front());
            end
        end
    end

    task automatic pulse_start();
        @(posedge Phi2); #1 Start_s1 = 1'b1;
        @(posedge Phi2); #1 Start_s1 = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        @(negedge Phi2);
        while (!Done_s1 && n < budget) begin
            @(negedge Phi2);
            n++;
        end
        chk({name, "_done_reached"}, Done_s1, 1);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_ready"}, Input_Ready_s1, 0);
        chk({name, "_valid"}, Result_Valid_s1, 0);
        chk({name, "_result"}, Result_s1, 0);
        chk({name, "_done"}, Done_s1, 0);
    endtask

    task automatic do_reset(input string name, input bit check_outs);
        @(negedge Phi2);
        Reset_n_s1 = 1'b0;
        #1;
        if (check_outs) check_idle_outputs(name);
        repeat (3) @(negedge Phi2);
        byte_q.delete();
        exp_q.delete();
    endtask

    // with_kernel: DUT is held in reset; release it and feed kernel + image.
    // Otherwise the DUT sits in DONE and is restarted with Start_s1.
    task automatic run_phase(input string name, input bit with_kernel, input bit mid_start);
        int p0, idx22, n;
        p0      = pop_total;
        idx22   = p0 + (with_kernel ? NUM_K : 0) + 2*W + 2;
        res_cnt = 0;
        req_cnt = 0;
        underflow = 0;
        if (with_kernel) for (int k = 0; k < NUM_K; k++) byte_q.push_back(kern[k]);
        for (int i = 0; i < W*H; i++) byte_q.push_back(img[i]);
        push_expected();
        if (with_kernel) begin
            @(negedge Phi2);
            Reset_n_s1 = 1'b1;
            @(posedge Phi2); #1;
            chk({name, "_ready_after_reset"}, Input_Ready_s1, 1);
        end else begin
            pulse_start();
        end
        if (mid_start) begin
            n = 0;
            while (pop_total < p0 + 40 && n < 300) begin
                @(negedge Phi2);
                n++;
            end
            pulse_start();
        end
        wait_done(name, 600);
        chk({name, "_result_count"}, res_cnt, NRES);
        chk({name, "_model_left"}, exp_q.size(), 0);
        chk({name, "_requests"}, req_cnt, with_kernel ? NUM_K + W*H : W*H);
        chk({name, "_underflow"}, underflow, 0);
        chk({name, "_bytes_left"}, byte_q.size(), 0);
        chk({name, "_ready_idle"}, Input_Ready_s1, 0);
        chk({name, "_first_latency"}, first_cyc, smp_edge[idx22] + 2);
    endtask

    initial begin : main
        int p0, n;
        Reset_n_s1 = 1'b1;
        Start_s1   = 1'b0;
        #3 Reset_n_s1 = 1'b0;
        repeat (3) @(negedge Phi2);
        check_idle_outputs("reset");

        // Identity kernel on a coordinate-coded image.
        for (int k = 0; k < NUM_K; k++) kern[k] = 8'sd0;
        kern[4] = 8'sd1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r*W + c] = 8'(10*r + c);
        run_phase("identity", 1'b1, 1'b0);
        chk("identity_first_value", first_res, 11);
        // Centre of the bottom-right window is pixel (7,8).
        chk("identity_last_value", last_res, 78);

        // Restart from DONE with a random image, kernel retained.
        for (int i = 0; i < W*H; i++) img[i] = 8'($urandom);
        run_phase("restart_identity", 1'b0, 1'b0);

        // Reset in the middle of an image.
        do_reset("pre_partial", 1'b0);
        for (int k = 0; k < NUM_K; k++) kern[k] = 8'($urandom);
        for (int i = 0; i < W*H; i++) img[i] = 8'($urandom);
        for (int k = 0; k < NUM_K; k++) byte_q.push_back(kern[k]);
        for (int i = 0; i < W*H; i++) byte_q.push_back(img[i]);
        push_expected();
        p0 = pop_total;
        @(negedge Phi2);
        Reset_n_s1 = 1'b1;
        n = 0;
        while (pop_total < p0 + NUM_K + 40 && n < 300) begin
            @(negedge Phi2);
            n++;
        end
        chk("partial_reached_40", pop_total >= p0 + NUM_K + 40, 1);
        do_reset("midimage_reset", 1'b1);

        // All-ones kernel, saturated image; Start_s1 during LOAD_IMAGE must be ignored.
        for (int k = 0; k < NUM_K; k++) kern[k] = 8'sd1;
        for (int i = 0; i < W*H; i++) img[i] = 8'hFF;
        run_phase("ones", 1'b1, 1'b1);
`ifdef CONV3X3_SAT_EN
        chk("ones_first_value", first_res, 255);
`else
        chk("ones_first_value", first_res, 2295);
`endif

        // All -1 kernel, flat image of 100.
        do_reset("pre_neg", 1'b0);
        for (int k = 0; k < NUM_K; k++) kern[k] = -8'sd1;
        for (int i = 0; i < W*H; i++) img[i] = 8'd100;
        run_phase("negative", 1'b1, 1'b0);
`ifdef CONV3X3_SAT_EN
        chk("negative_first_value", first_res, 0);
`else
        chk("negative_first_value", first_res, -900);
`endif
        for (int i = 0; i < W*H; i++) img[i] = 8'($urandom);
        run_phase("restart_negative", 1'b0, 1'b0);

        // Fully random kernel and images.
        do_reset("pre_random", 1'b0);
        for (int k = 0; k < NUM_K; k++) kern[k] = 8'($urandom);
        for (int i = 0; i < W*H; i++) img[i] = 8'($urandom);
        run_phase("random", 1'b1, 1'b0);
        for (int i = 0; i < W*H; i++) img[i] = 8'($urandom);
        run_phase("restart_random", 1'b0, 1'b0);

        repeat (3) @(negedge Phi2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
